// File: rtl/pkg_rv32_types.sv
// Shared RV32 type definitions: immediate format selector.
// Values 5..7 are deliberately left unused so illegal selectors can be detected.
package pkg_rv32_types;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

endpackage

// File: rtl/rv32_imm_encoder_if.sv
// Bundle of the encoder's request/response streams plus the error-counter port.
// The master side issues requests and consumes results; the slave side is the encoder.
interface rv32_imm_encoder_if #(
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 16
);
  import pkg_rv32_types::*;

  logic                 s_valid;
  logic                 s_ready;
  logic [31:0]          s_inst_base;
  imm_type_e            s_imm_type;
  logic [31:0]          s_imm;
  logic [TAG_W-1:0]     s_tag;

  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          m_inst;
  logic [TAG_W-1:0]     m_tag;
  logic                 m_range_err;
  logic                 m_align_err;
  logic                 m_type_err;

  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clr;

  modport master (
    output s_valid, s_inst_base, s_imm_type, s_imm, s_tag, m_ready, err_clr,
    input  s_ready, m_valid, m_inst, m_tag, m_range_err, m_align_err, m_type_err, err_count
  );

  modport slave (
    input  s_valid, s_inst_base, s_imm_type, s_imm, s_tag, m_ready, err_clr,
    output s_ready, m_valid, m_inst, m_tag, m_range_err, m_align_err, m_type_err, err_count
  );

endinterface

// File: rtl/rv32_imm_encoder.sv
// Two-stage pipelined RV32 immediate encoder: scatters a signed immediate into the
// I/S/B/U/J field positions of a template instruction, flags range/alignment/type
// problems per transaction and keeps a saturating count of erroneous deliveries.
module rv32_imm_encoder #(
  parameter int TAG_W       = 4,
  parameter int ERR_CNT_W   = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  rv32_imm_encoder_if.slave bus
);
  import pkg_rv32_types::*;

  // Combinational encode of the incoming request
  logic [31:0]      w_imm;
  logic [31:0]      w_inst;
  logic             w_range;
  logic             w_align;
  logic             w_type;

  // Pipeline control
  logic             w_ld1;
  logic             w_ld2;
  logic             w_acc;
  logic             w_hs;
  logic             w_any_err;

  // Stage 1
  logic             r_v1;
  logic [31:0]      r_inst1;
  logic [TAG_W-1:0] r_tag1;
  logic [2:0]       r_flags1;   // {type, align, range}

  // Stage 2 (output register)
  logic             r_v2;
  logic [31:0]      r_inst2;
  logic [TAG_W-1:0] r_tag2;
  logic [2:0]       r_flags2;

  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_imm = bus.s_imm;

  // Scatter immediate bits into the selected format and evaluate the checks
  always_comb begin
    w_inst  = bus.s_inst_base;
    w_range = 1'b0;
    w_align = 1'b0;
    w_type  = 1'b0;
    case (bus.s_imm_type)
      IMM_I: begin
        w_inst[31:20] = w_imm[11:0];
        w_range       = !((&w_imm[31:11]) | ~(|w_imm[31:11]));
      end
      IMM_S: begin
        w_inst[31:25] = w_imm[11:5];
        w_inst[11:7]  = w_imm[4:0];
        w_range       = !((&w_imm[31:11]) | ~(|w_imm[31:11]));
      end
      IMM_B: begin
        w_inst[31]    = w_imm[12];
        w_inst[7]     = w_imm[11];
        w_inst[30:25] = w_imm[10:5];
        w_inst[11:8]  = w_imm[4:1];
        w_range       = !((&w_imm[31:12]) | ~(|w_imm[31:12]));
        w_align       = CHECK_ALIGN & w_imm[0];
      end
      IMM_U: begin
        w_inst[31:12] = w_imm[31:12];
        w_align       = CHECK_ALIGN & (|w_imm[11:0]);
      end
      IMM_J: begin
        w_inst[31]    = w_imm[20];
        w_inst[19:12] = w_imm[19:12];
        w_inst[20]    = w_imm[11];
        w_inst[30:21] = w_imm[10:1];
        w_range       = !((&w_imm[31:20]) | ~(|w_imm[31:20]));
        w_align       = CHECK_ALIGN & w_imm[0];
      end
      default: begin
        // Unknown format: pass the template through untouched, flag only the type
        w_type = 1'b1;
      end
    endcase
  end

  // Stage 2 advances when empty or when its content is being consumed;
  // stage 1 advances when empty or when stage 2 is taking its content.
  assign w_ld2     = !r_v2 | bus.m_ready;
  assign w_ld1     = !r_v1 | w_ld2;
  assign w_acc     = bus.s_valid & w_ld1;
  assign w_hs      = r_v2 & bus.m_ready;
  assign w_any_err = |r_flags2;

  // Stage 1 register: capture the encode result on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_inst1  <= '0;
      r_tag1   <= '0;
      r_flags1 <= '0;
    end else if (w_ld1) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_inst1  <= w_inst;
        r_tag1   <= bus.s_tag;
        r_flags1 <= {w_type, w_align, w_range};
      end
    end
  end

  // Stage 2 register: data only moves when a real transaction arrives, so the
  // outputs hold their last value (or reset value) while idle or stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r_inst2  <= '0;
      r_tag2   <= '0;
      r_flags2 <= '0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_inst2  <= r_inst1;
        r_tag2   <= r_tag1;
        r_flags2 <= r_flags1;
      end
    end
  end

  // Saturating count of erroneous deliveries; clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (w_hs && w_any_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.s_ready     = w_ld1;
  assign bus.m_valid     = r_v2;
  assign bus.m_inst      = r_inst2;
  assign bus.m_tag       = r_tag2;
  assign bus.m_range_err = r_flags2[0];
  assign bus.m_align_err = r_flags2[1];
  assign bus.m_type_err  = r_flags2[2];
  assign bus.err_count   = r_err_cnt;

endmodule

// File: tb/tb_rv32_imm_encoder.sv
// Randomized plus directed bench for rv32_imm_encoder. A scoreboard queue records
// accepted requests; each delivered result is decoded with a core-style immediate
// generator and compared with an arithmetic model of range/alignment rules.
module tb_rv32_imm_encoder;
  import pkg_rv32_types::*;

  localparam int TAG_W = 4;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_imm_encoder_if #(.TAG_W(TAG_W), .ERR_CNT_W(CW)) bus ();

  rv32_imm_encoder #(.TAG_W(TAG_W), .ERR_CNT_W(CW), .CHECK_ALIGN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0]       t;
    logic [31:0]      imm;
    logic [31:0]      base;
    logic [TAG_W-1:0] tag;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;
  bit   rnd_ready = 0;
  bit   ready_hold = 1;
  int   model_cnt = 0;
  bit   pend_inc = 0;
  bit   prev_stall = 0;
  logic [31:0] prev_inst;
  logic [TAG_W-1:0] prev_tag;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Core immediate generator (decode side), used for the round trip
  function automatic logic [31:0] core_immgen(input logic [2:0] t, input logic [31:0] i);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  // Arithmetic model: flags {type,align,range}, mask of immediate-owned bits,
  // and the value the decoder must recover (wrapped into the field width)
  function automatic void ref_model(input logic [2:0] t, input logic [31:0] imm,
                                    output logic [2:0] flags, output logic [31:0] mask,
                                    output logic [31:0] dec);
    longint v;
    v = longint'($signed(imm));
    flags = 3'b000; mask = 32'd0; dec = 32'd0;
    case (t)
      3'd0, 3'd1: begin
        flags[0] = (v < -2048) || (v > 2047);
        dec  = ((imm + 32'd2048) & 32'hFFF) - 32'd2048;
        mask = (t == 3'd0) ? 32'hFFF0_0000 : 32'hFE00_0F80;
      end
      3'd2: begin
        flags[0] = (v < -4096) || (v > 4095);
        flags[1] = (imm % 2) != 0;
        dec  = (((imm + 32'd4096) & 32'h1FFF) - 32'd4096) & ~32'd1;
        mask = 32'hFE00_0F80;
      end
      3'd3: begin
        flags[1] = (imm % 4096) != 0;
        dec  = imm - (imm % 4096);
        mask = 32'hFFFF_F000;
      end
      3'd4: begin
        flags[0] = (v < -1048576) || (v > 1048575);
        flags[1] = (imm % 2) != 0;
        dec  = (((imm + 32'h10_0000) & 32'h1F_FFFF) - 32'h10_0000) & ~32'd1;
        mask = 32'hFFFF_F000;
      end
      default: flags[2] = 1'b1;
    endcase
  endfunction

  // Downstream ready: random or held, changed just after the active edge
  always @(posedge clk) begin
    #1;
    bus.m_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  // Error-counter model, advanced at the same edge the DUT counter moves
  always @(posedge clk) begin
    if (rst) model_cnt = 0;
    else if (bus.err_clr) model_cnt = 0;
    else if (pend_inc && model_cnt < (1 << CW) - 1) model_cnt = model_cnt + 1;
  end

  // Monitor: record accepts, check deliveries, stall stability and the counter
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      prev_stall = 0;
      pend_inc   = 0;
    end else begin
      txn_t       x;
      logic [2:0] f;
      logic [31:0] m, d;
      check_eq("err_count", 32'(bus.err_count), 32'(model_cnt));
      if (prev_stall) begin
        check_eq("stall_inst", bus.m_inst, prev_inst);
        check_eq("stall_tag", 32'(bus.m_tag), 32'(prev_tag));
      end
      if (bus.s_valid && bus.s_ready)
        exp_q.push_back('{t: bus.s_imm_type, imm: bus.s_imm, base: bus.s_inst_base, tag: bus.s_tag});
      pend_inc = 0;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", 32'(bus.m_tag), 32'hFFFF_FFFF);
        end else begin
          x = exp_q.pop_front();
          ref_model(x.t, x.imm, f, m, d);
          check_eq("tag", 32'(bus.m_tag), 32'(x.tag));
          check_eq("flags", 32'({bus.m_type_err, bus.m_align_err, bus.m_range_err}), 32'(f));
          check_eq("base_bits", bus.m_inst & ~m, x.base & ~m);
          if (f[2]) check_eq("illegal_inst", bus.m_inst, x.base);
          else      check_eq("roundtrip", core_immgen(x.t, bus.m_inst), d);
          pend_inc = |f;
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_inst  = bus.m_inst;
      prev_tag   = bus.m_tag;
    end
  end

  // Offer one request (called just after an active edge); returns just after the accept edge
  task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base,
                      input logic [TAG_W-1:0] tag);
    int w;
    w = 0;
    bus.s_valid = 1'b1; bus.s_imm_type = imm_type_e'(t);
    bus.s_imm = imm; bus.s_inst_base = base; bus.s_tag = tag;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      w++;
      if (w > 200) begin
        check_eq("send_timeout", 32'(bus.s_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    $display("txn tag=%0d type=%0d imm=0x%08h base=0x%08h accepted", tag, t, imm, base);
  endtask

  task automatic expect_out(input string name, input logic [31:0] inst, input logic [2:0] flags);
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) break;
      w++;
      if (w > 200) break;
    end
    check_eq({name, "_valid"}, 32'(bus.m_valid), 32'd1);
    check_eq({name, "_inst"}, bus.m_inst, inst);
    check_eq({name, "_flags"}, 32'({bus.m_type_err, bus.m_align_err, bus.m_range_err}), 32'(flags));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_ready(input bit r);
    @(posedge clk); #2;
    ready_hold = r;
    bus.m_ready = r;
  endtask

  function automatic logic [31:0] sext(input logic [31:0] r, input int w);
    logic [31:0] lo, sb;
    lo = r & ((32'd1 << w) - 32'd1);
    sb = 32'd1 << (w - 1);
    return (lo ^ sb) - sb;
  endfunction

  initial begin
    logic [2:0]  t;
    logic [31:0] imm, r;
    int          wid;

    bus.s_valid = 0; bus.s_inst_base = 0; bus.s_imm_type = IMM_I;
    bus.s_imm = 0; bus.s_tag = 0; bus.m_ready = 1; bus.err_clr = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rst_m_inst", bus.m_inst, 32'd0);
    check_eq("rst_m_tag", 32'(bus.m_tag), 32'd0);
    check_eq("rst_flags", 32'({bus.m_type_err, bus.m_align_err, bus.m_range_err}), 32'd0);
    check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
    rst = 0;
    mon_en = 1;
    check_eq("rst_s_ready", 32'(bus.s_ready), 32'd1);

    // I-type limits and latency
    send(3'd0, 32'hFFFF_F800, 32'h0000_0013, 4'd1);
    check_eq("lat_k1_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("lat_k2_valid", 32'(bus.m_valid), 32'd1);
    check_eq("i_min_inst", bus.m_inst, 32'h8000_0013);
    check_eq("i_min_flags", 32'({bus.m_type_err, bus.m_align_err, bus.m_range_err}), 32'd0);
    send(3'd0, 32'h0000_0800, 32'h0000_0013, 4'd2);
    expect_out("i_over", 32'h8000_0013, 3'b001);
    drain();
    check_eq("cnt_after_i", 32'(bus.err_count), 32'd1);

    // Branch, jump, upper
    send(3'd2, 32'hFFFF_FFFE, 32'h0000_0063, 4'd3);
    expect_out("b_neg2", 32'hFE00_0FE3, 3'b000);
    send(3'd2, 32'h0000_0003, 32'h0000_0063, 4'd4);
    expect_out("b_odd", 32'h0000_0163, 3'b010);
    send(3'd2, 32'h0000_1000, 32'h0000_0063, 4'd5);
    expect_out("b_over", 32'h8000_0063, 3'b001);
    send(3'd4, 32'h0000_0800, 32'h0000_006F, 4'd6);
    expect_out("j_800", 32'h0010_006F, 3'b000);
    send(3'd3, 32'h1234_5000, 32'h0000_0037, 4'd7);
    expect_out("u_ok", 32'h1234_5037, 3'b000);
    send(3'd3, 32'h1234_5001, 32'h0000_0037, 4'd8);
    expect_out("u_misalign", 32'h1234_5037, 3'b010);
    drain();
    check_eq("cnt_after_dir", 32'(bus.err_count), 32'd4);

    // Backpressure: two buffered, third held off, then released in order
    set_ready(0);
    send(3'd0, 32'd1, 32'h0000_0013, 4'd1);
    send(3'd0, 32'd2, 32'h0000_0013, 4'd2);
    bus.s_valid = 1; bus.s_imm_type = IMM_I; bus.s_imm = 32'd3;
    bus.s_inst_base = 32'h0000_0013; bus.s_tag = 4'd3;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_s_ready", 32'(bus.s_ready), 32'd0);
      check_eq("bp_head_tag", 32'(bus.m_tag), 32'd1);
    end
    set_ready(1);
    fork
      send(3'd0, 32'd3, 32'h0000_0013, 4'd3);
      begin
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          check_eq("bp_order_valid", 32'(bus.m_valid), 32'd1);
          check_eq("bp_order_tag", 32'(bus.m_tag), 32'(k));
        end
      end
    join
    drain();

    // Illegal format selector
    send(3'd5, 32'hABCD_E123, 32'h1234_5678, 4'd9);
    expect_out("illegal", 32'h1234_5678, 3'b100);
    drain();

    // Randomized round trip
    rnd_ready = 1;
    for (int n = 0; n < 10000; n++) begin
      t = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      r = $urandom;
      wid = (t == 3'd2) ? 13 : (t == 3'd4) ? 21 : 12;
      case ($urandom_range(0, 3))
        0: imm = r;
        1: imm = (t == 3'd3) ? (r & 32'hFFFF_F000) : (sext(r, wid) & ((t == 3'd2 || t == 3'd4) ? ~32'd1 : ~32'd0));
        2: imm = (t == 3'd3) ? (r & 32'hFFFF_F001) : sext(r, wid);
        default: imm = r[0] ? ((32'd1 << (wid - 1)) - 32'(r[1] ? 1 : 0) - 32'(r[2] ? 1 : 0))
                            : (32'd0 - (32'd1 << (wid - 1)) - 32'(r[1] ? 1 : 0));
      endcase
      send(t, imm, $urandom, 4'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_ready = 0;
    set_ready(1);
    drain();

    // Saturation
    bus.err_clr = 1;
    @(posedge clk); #1;
    bus.err_clr = 0;
    check_eq("clr_count", 32'(bus.err_count), 32'd0);
    for (int n = 0; n < 17; n++) send(3'd0, 32'h0000_1000, 32'h0000_0013, 4'(n));
    drain();
    check_eq("sat_count", 32'(bus.err_count), 32'd15);

    // Clear coincident with an error handshake
    send(3'd0, 32'h0000_1000, 32'h0000_0013, 4'd4);
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) break;
    end
    bus.err_clr = 1;
    @(posedge clk); #1;
    bus.err_clr = 0;
    check_eq("clr_wins", 32'(bus.err_count), 32'd0);
    drain();

    // Asynchronous reset with two transactions in flight
    set_ready(0);
    send(3'd0, 32'd10, 32'h0000_0013, 4'd10);
    send(3'd0, 32'd11, 32'h0000_0013, 4'd11);
    #3;
    rst = 1;
    mon_en = 0;
    exp_q.delete();
    #1;
    check_eq("arst_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("arst_m_inst", bus.m_inst, 32'd0);
    @(posedge clk); #2;
    rst = 0;
    ready_hold = 1;
    bus.m_ready = 1;
    mon_en = 1;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_idle", 32'(bus.m_valid), 32'd0);
    end
    @(posedge clk); #1;
    send(3'd1, 32'hFFFF_FFFB, 32'h0000_0023, 4'd12);
    expect_out("s_neg5", 32'hFE00_0DA3, 3'b000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
